bram_sav_ctrl: RTL
==================

BRAM_SAV_CTRL -- requirements
Module: bram_sav_ctrl

Interface
REQ-001 SHALL have parameter SECTORS, default 128, giving the number of 512-byte sectors per backup image (power of two, 2..128).
REQ-002 SHALL have parameter TIMEOUT, default 24'd5000000, giving the maximum clk_sys cycles to wait on any sd_ack edge.
REQ-003 SHALL have port clk_sys, input, 1 bit: the single system clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port downloading, input, 1 bit: cart download in progress.
REQ-006 SHALL have port img_mounted, input, 1 bit: one-cycle pulse when the save image is mounted.
REQ-007 SHALL have port img_readonly, input, 1 bit: the mounted image is read-only.
REQ-008 SHALL have port img_size_nz, input, 1 bit: the mounted image size is nonzero.
REQ-009 SHALL have port load_req, input, 1 bit: menu load level; acts on its rising edge.
REQ-010 SHALL have port save_req, input, 1 bit: menu save level; acts on its rising edge.
REQ-011 SHALL have port autosave_en, input, 1 bit: autosave option.
REQ-012 SHALL have port osd_open, input, 1 bit: OSD visible.
REQ-013 SHALL have port bram_change, input, 1 bit: the core wrote backup RAM.
REQ-014 SHALL have port sd_ack, input, 1 bit: HPS sector handshake.
REQ-015 SHALL have port sd_lba, output, 32 bits: current sector.
REQ-016 SHALL have ports sd_rd and sd_wr, outputs, 1 bit each: sector requests.
REQ-017 SHALL have port bk_ena, output, 1 bit: a writable save image is available.
REQ-018 SHALL have port bk_loading, output, 1 bit: load in progress; the top level ORs it into the core reset.
REQ-019 SHALL have port busy, output, 1 bit: a transfer is active.
REQ-020 SHALL have port sav_pending, output, 1 bit: unsaved changes exist (drives LED).
REQ-021 SHALL have port timeout_err, output, 1 bit: the last transfer aborted.

Function
REQ-022 bk_ena SHALL clear on the rising edge of downloading, and SHALL set when downloading && img_mounted && !img_readonly.
REQ-023 sav_pending SHALL set on bram_change && !osd_open, and SHALL clear on entry to ISSUE of a save; if both occur in the same cycle, set wins.
REQ-024 Autosave SHALL start a save when state is IDLE && bk_ena && autosave_en && sav_pending && osd_open.
REQ-025 An auto-load SHALL start on the falling edge of downloading when bk_ena && img_size_nz.
REQ-026 Start priority in IDLE SHALL be: auto-load, then load_req edge, then save_req edge, then autosave; only one start per cycle, and losing edges are dropped.
REQ-027 Starts SHALL be ignored while !bk_ena, except the auto-load, which requires bk_ena by definition.
REQ-028 The state machine SHALL have states IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE.
REQ-029 On a start (IDLE -> ISSUE): sd_lba = 0, mode latched (load/save), busy = 1, bk_loading = load, timeout_err = 0.
REQ-030 In ISSUE, the controller SHALL assert sd_rd (load) or sd_wr (save) for one cycle, then go to WAIT_HI.
REQ-031 In WAIT_HI, the request SHALL stay asserted until sd_ack rises; on that rising edge it SHALL drop sd_rd/sd_wr in the same cycle and go to WAIT_LO.
REQ-032 In WAIT_LO, on the falling edge of sd_ack: if sd_lba == SECTORS-1, go to DONE; else increment sd_lba and go to ISSUE.
REQ-033 DONE SHALL last one cycle: busy = 0, bk_loading = 0, then go to IDLE.
REQ-034 sd_ack edges SHALL be detected against a one-cycle registered copy of sd_ack; the latency from an ack edge to the response is 1 cycle.
REQ-035 A timeout counter SHALL reload on every state entry; if it reaches TIMEOUT in WAIT_HI or WAIT_LO, the controller SHALL drop requests, set timeout_err, and go to DONE.
REQ-036 The rising edge of downloading during a transfer SHALL abort it via the same path as a timeout, except that timeout_err stays 0.
REQ-037 sd_lba[31:7] SHALL always be 0; increments never wrap past SECTORS-1.

Reset
REQ-038 reset_n low SHALL immediately force: state IDLE, sd_lba = 0, sd_rd = sd_wr = 0, bk_ena = 0, bk_loading = 0, busy = 0, sav_pending = 0, timeout_err = 0, edge registers = 0.
REQ-039 Reset mid-transfer SHALL abandon the transfer with no further request issued, and SHALL NOT restart it after release.

Structure
REQ-040 The state enum bk_state_t and the SECTORS/TIMEOUT defaults SHALL reside in the shared package bram_sav_pkg.
REQ-041 Edge detection plus the timeout counter SHALL be one sub-module, sav_watchdog; everything else SHALL be a single always_ff block plus its next-state logic.

Verification
REQ-042 Download 1->0 with bk_ena = 1 and img_size_nz = 1, HPS acking each request after 10 cycles: 128 sd_rd pulses, sd_lba 0..127, bk_loading high throughout, busy low 1 cycle after the 128th ack falls.
REQ-043 save_req rising with bk_ena = 1: 128 sd_wr requests; sd_wr drops the cycle after each sd_ack rise; bk_loading stays 0.
REQ-044 bram_change with osd_open = 0, then osd_open = 1 and autosave_en = 1: sav_pending = 1, save starts, sav_pending = 0 at ISSUE.
REQ-045 load_req and save_req rising in the same cycle: a load runs and the save is dropped.
REQ-046 sd_ack never rises with TIMEOUT = 100: timeout_err = 1 and busy = 0 at cycle 102 after ISSUE.
REQ-047 reset_n pulled low at sd_lba = 37: all outputs 0 immediately, and no sd_rd after release.

Source files
------------

// File: rtl/bram_sav_pkg.sv
// Shared types and defaults for the backup-RAM save/load controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bram_sav_pkg;

  localparam int          SECTORS_DEF = 128;
  localparam logic [23:0] TIMEOUT_DEF = 24'd5000000;
  // Sector index width; 128 sectors is the largest image, so sd_lba[31:7] is always zero.
  localparam int          LBA_W       = 7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    DONE
  } bk_state_t;

endpackage

// File: rtl/sav_watchdog.sv
// Edge detectors for sd_ack/downloading/menu requests plus the per-state timeout counter.
// Latency: edges are combinational against a 1-cycle registered copy; expiry is registered.
// Backpressure: none; the counter saturates at TIMEOUT until the next restart.
module sav_watchdog
  import bram_sav_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic sd_ack,
  input  logic downloading,
  input  logic load_req,
  input  logic save_req,
  input  logic restart,
  output logic ack_rise,
  output logic ack_fall,
  output logic dl_rise,
  output logic dl_fall,
  output logic load_rise,
  output logic save_rise,
  output logic expired
);

  logic        sd_ack_q, dl_q, load_q, save_q;
  logic [23:0] cnt_q, cnt_d;

  // Counter restarts whenever the controller changes state and holds once it hits TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q != TIMEOUT) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  // One-cycle history of the level inputs, and the counter register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sd_ack_q <= 1'b0;
      dl_q     <= 1'b0;
      load_q   <= 1'b0;
      save_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sd_ack_q <= sd_ack;
      dl_q     <= downloading;
      load_q   <= load_req;
      save_q   <= save_req;
      cnt_q    <= cnt_d;
    end
  end

  assign ack_rise  = sd_ack & ~sd_ack_q;
  assign ack_fall  = ~sd_ack & sd_ack_q;
  assign dl_rise   = downloading & ~dl_q;
  assign dl_fall   = ~downloading & dl_q;
  assign load_rise = load_req & ~load_q;
  assign save_rise = save_req & ~save_q;
  assign expired   = (cnt_q == TIMEOUT);

endmodule

// File: rtl/bram_sav_ctrl.sv
// Backup-RAM save/load sequencer: streams SECTORS sectors to/from the HPS via sd_rd/sd_wr.
// Latency: start edge -> request 1 cycle; sd_ack edge -> response 1 cycle.
// Backpressure: each sector waits on the sd_ack rise/fall handshake, bounded by TIMEOUT.
module bram_sav_ctrl
  import bram_sav_pkg::*;
#(
  parameter int          SECTORS = SECTORS_DEF,
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        downloading,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        img_size_nz,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        autosave_en,
  input  logic        osd_open,
  input  logic        bram_change,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_ena,
  output logic        bk_loading,
  output logic        busy,
  output logic        sav_pending,
  output logic        timeout_err
);

  localparam logic [LBA_W-1:0] LAST = LBA_W'(SECTORS - 1);

  bk_state_t        state_q, state_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic             load_mode_q, load_mode_d;
  logic             sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic             busy_q, busy_d, bk_loading_q, bk_loading_d;
  logic             timeout_err_q, timeout_err_d;
  logic             bk_ena_q, bk_ena_d, sav_pending_q, sav_pending_d;
  logic             start_load, start_save, restart;
  logic             ack_rise, ack_fall, dl_rise, dl_fall, load_rise, save_rise, expired;

  assign restart = (state_d != state_q);

  sav_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .sd_ack      (sd_ack),
    .downloading (downloading),
    .load_req    (load_req),
    .save_req    (save_req),
    .restart     (restart),
    .ack_rise    (ack_rise),
    .ack_fall    (ack_fall),
    .dl_rise     (dl_rise),
    .dl_fall     (dl_fall),
    .load_rise   (load_rise),
    .save_rise   (save_rise),
    .expired     (expired)
  );

  // Next-state logic: start arbitration, per-sector handshake, aborts, and the status flags.
  always_comb begin
    state_d       = state_q;
    lba_d         = lba_q;
    load_mode_d   = load_mode_q;
    sd_rd_d       = sd_rd_q;
    sd_wr_d       = sd_wr_q;
    busy_d        = busy_q;
    bk_loading_d  = bk_loading_q;
    timeout_err_d = timeout_err_q;
    bk_ena_d      = bk_ena_q;
    sav_pending_d = sav_pending_q;
    start_load    = 1'b0;
    start_save    = 1'b0;

    case (state_q)
      IDLE: begin
        // Auto-load first; user/auto starts need a writable image and are dropped on a new download.
        if (dl_fall && bk_ena_q && img_size_nz) begin
          start_load = 1'b1;
        end else if (bk_ena_q && !dl_rise) begin
          if (load_rise)                                    start_load = 1'b1;
          else if (save_rise)                               start_save = 1'b1;
          else if (autosave_en && sav_pending_q && osd_open) start_save = 1'b1;
        end
        if (start_load || start_save) begin
          state_d       = ISSUE;
          lba_d         = '0;
          load_mode_d   = start_load;
          busy_d        = 1'b1;
          bk_loading_d  = start_load;
          timeout_err_d = 1'b0;
          sd_rd_d       = start_load;
          sd_wr_d       = start_save;
          // Only the start of a save consumes the pending flag; writes during the save re-arm it.
          if (start_save) sav_pending_d = 1'b0;
        end
      end
      ISSUE: begin
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (ack_rise) begin
          state_d = WAIT_LO;
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
        end else if (expired) begin
          state_d       = DONE;
          sd_rd_d       = 1'b0;
          sd_wr_d       = 1'b0;
          busy_d        = 1'b0;
          bk_loading_d  = 1'b0;
          timeout_err_d = 1'b1;
        end
      end
      WAIT_LO: begin
        if (ack_fall) begin
          if (lba_q == LAST) begin
            state_d      = DONE;
            busy_d       = 1'b0;
            bk_loading_d = 1'b0;
          end else begin
            state_d = ISSUE;
            lba_d   = lba_q + 1'b1;
            sd_rd_d = load_mode_q;
            sd_wr_d = ~load_mode_q;
          end
        end else if (expired) begin
          state_d       = DONE;
          busy_d        = 1'b0;
          bk_loading_d  = 1'b0;
          timeout_err_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new cart download kills any transfer in flight without flagging an error.
    if (dl_rise && (state_q == ISSUE || state_q == WAIT_HI || state_q == WAIT_LO)) begin
      state_d       = DONE;
      sd_rd_d       = 1'b0;
      sd_wr_d       = 1'b0;
      busy_d        = 1'b0;
      bk_loading_d  = 1'b0;
      timeout_err_d = timeout_err_q;
    end

    if (dl_rise) bk_ena_d = 1'b0;
    if (downloading && img_mounted && !img_readonly) bk_ena_d = 1'b1;

    // A fresh core write beats a simultaneous save start.
    if (bram_change && !osd_open) sav_pending_d = 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      lba_q         <= '0;
      load_mode_q   <= 1'b0;
      sd_rd_q       <= 1'b0;
      sd_wr_q       <= 1'b0;
      busy_q        <= 1'b0;
      bk_loading_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      bk_ena_q      <= 1'b0;
      sav_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lba_q         <= lba_d;
      load_mode_q   <= load_mode_d;
      sd_rd_q       <= sd_rd_d;
      sd_wr_q       <= sd_wr_d;
      busy_q        <= busy_d;
      bk_loading_q  <= bk_loading_d;
      timeout_err_q <= timeout_err_d;
      bk_ena_q      <= bk_ena_d;
      sav_pending_q <= sav_pending_d;
    end
  end

  assign sd_lba      = {{(32 - LBA_W){1'b0}}, lba_q};
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign busy        = busy_q;
  assign bk_loading  = bk_loading_q;
  assign timeout_err = timeout_err_q;
  assign bk_ena      = bk_ena_q;
  assign sav_pending = sav_pending_q;

endmodule
